// File: rtl/alu_exec_unit_if.sv
// Valid/ready request/response bundle between the register-read stage,
// alu_exec_unit and writeback.
interface alu_exec_unit_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       ALUControl;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output in_valid, ALUControl, a, b, out_ready,
    input  in_ready, out_valid, result, zero
  );

  modport slave (
    input  in_valid, ALUControl, a, b, out_ready,
    output in_ready, out_valid, result, zero
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshake; shifts run 1 bit per cycle
// unless ALU_FAST_SHIFT_EN is defined, which builds a single-cycle barrel shifter.
module alu_exec_unit #(
  parameter int WIDTH = 32
) (
  input  logic           clk,
  input  logic           reset,
  alu_exec_unit_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLT = 3'b101,
    OP_SLL = 3'b110,
    OP_SRL = 3'b111
  } op_t;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  op_t              op;
  logic [SHW-1:0]   shamt;
  logic             accept;
  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;

  assign op            = op_t'(bus.ALUControl);
  assign shamt         = bus.b[SHW-1:0];
  assign bus.in_ready  = (state == IDLE) | ((state == DONE) & bus.out_ready);
  assign accept        = bus.in_valid & bus.in_ready;
  assign bus.out_valid = (state == DONE);
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;

  // Single-cycle result; shifts only reach here with shamt==0 in the iterative build.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    alu_y = '0;
    case (op)
      OP_ADD: alu_y = bus.a + bus.b;
      OP_SUB: alu_y = bus.a - bus.b;
      OP_AND: alu_y = bus.a & bus.b;
      OP_OR:  alu_y = bus.a | bus.b;
      OP_XOR: alu_y = bus.a ^ bus.b;
      OP_SLT: alu_y = {{(WIDTH-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
`ifdef ALU_FAST_SHIFT_EN
      OP_SLL: alu_y = bus.a << shamt;
      OP_SRL: alu_y = bus.a >> shamt;
`else
      OP_SLL: alu_y = bus.a;
      OP_SRL: alu_y = bus.a;
`endif
    endcase
  end

`ifndef ALU_FAST_SHIFT_EN
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [SHW-1:0]   cnt;
  logic             shift_left;
  logic             start_shift;

  assign start_shift = ((op == OP_SLL) || (op == OP_SRL)) && (shamt != '0);
  assign acc_next    = shift_left ? {acc[WIDTH-2:0], 1'b0} : {1'b0, acc[WIDTH-1:1]};
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
`ifndef ALU_FAST_SHIFT_EN
      acc        <= '0;
      cnt        <= '0;
      shift_left <= 1'b0;
`endif
    end else begin
      case (state)
`ifndef ALU_FAST_SHIFT_EN
        SHIFT: begin
          acc <= acc_next;
          cnt <= cnt - SHW'(1);
          if (cnt == SHW'(1)) begin
            result_q <= acc_next;
            zero_q   <= (acc_next == '0);
            state    <= DONE;
          end
        end
`endif
        default: begin
          // IDLE and DONE service an accept identically, giving back-to-back issue.
          if (accept) begin
`ifndef ALU_FAST_SHIFT_EN
            if (start_shift) begin
              acc        <= bus.a;
              cnt        <= shamt;
              shift_left <= (op == OP_SLL);
              state      <= SHIFT;
            end else
`endif
            begin
              result_q <= alu_y;
              zero_q   <= (alu_y == '0);
              state    <= DONE;
            end
          end else if ((state == DONE) && bus.out_ready) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed vectors, randomized ops
// against a behavioural model, backpressure, back-to-back and mid-shift reset.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   tests  = 0;
  int   failed = 0;

  alu_exec_unit_if #(.WIDTH(W)) bus ();

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural model: what each opcode means arithmetically.
  function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    int sh;
    sh = int'(y % 32);
    case (op)
      3'd0: return x + y;
      3'd1: return x - y;
      3'd2: return x & y;
      3'd3: return x | y;
      3'd4: return x ^ y;
      3'd5: return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      3'd6: return x << sh;
      default: return x >> sh;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] y);
    int sh;
    sh = int'(y % 32);
`ifdef ALU_FAST_SHIFT_EN
    return 1;
`else
    if (op >= 3'd6 && sh != 0) return sh + 1;
    return 1;
`endif
  endfunction

  // Issue one op from idle with out_ready=1, report result, zero and accept-to-valid edges.
  task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] r, output logic z, output int lat);
    bus.in_valid   = 1'b1;
    bus.ALUControl = op;
    bus.a          = x;
    bus.b          = y;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.in_valid   = 1'b0;
    bus.ALUControl = 3'($urandom);
    bus.a          = $urandom;
    bus.b          = $urandom;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (bus.out_valid !== 1'b1) lat = -1;
    r = bus.result;
    z = bus.zero;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      failed++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid);
    end
    tests++;
    if (bus.result !== 32'h0) begin
      failed++; $display("FAIL reset_result got=%h want=00000000", bus.result);
    end
    tests++;
    if (bus.zero !== 1'b1) begin
      failed++; $display("FAIL reset_zero got=%b want=1", bus.zero);
    end
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1) begin
      failed++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready);
    end
  endtask

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic        z;
  } vec_t;

  task automatic test_directed();
    vec_t        vecs [8];
    logic [31:0] r;
    logic        z;
    int          lat;
    vecs = '{
      '{3'd0, 32'd5,          32'd7,          32'h0000000C, 1'b0},
      '{3'd1, 32'd9,          32'd9,          32'h00000000, 1'b1},
      '{3'd5, 32'hFFFFFFFF,   32'd1,          32'h00000001, 1'b0},
      '{3'd5, 32'd1,          32'hFFFFFFFF,   32'h00000000, 1'b1},
      '{3'd4, 32'hF0F0F0F0,   32'hFFFF0000,   32'h0F0FF0F0, 1'b0},
      '{3'd6, 32'd1,          32'd4,          32'h00000010, 1'b0},
      '{3'd7, 32'h80000000,   32'd31,         32'h00000001, 1'b0},
      '{3'd6, 32'h000000AB,   32'h00000020,   32'h000000AB, 1'b0}
    };
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, z, lat);
      tests++;
      if (r !== vecs[i].r) begin
        failed++; $display("FAIL directed_result[%0d] got=%h want=%h", i, r, vecs[i].r);
      end
      tests++;
      if (z !== vecs[i].z) begin
        failed++; $display("FAIL directed_zero[%0d] got=%b want=%b", i, z, vecs[i].z);
      end
      tests++;
      if (lat != ref_lat(vecs[i].op, vecs[i].b)) begin
        failed++; $display("FAIL directed_latency[%0d] got=%0d want=%0d", i, lat, ref_lat(vecs[i].op, vecs[i].b));
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] x, y, exp, r;
    logic        z;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      op  = 3'($urandom_range(0, 7));
      x   = $urandom;
      y   = (i % 5 == 0) ? x : $urandom;
      exp = ref_alu(op, x, y);
      run_op(op, x, y, r, z, lat);
      tests++;
      if (r !== exp || z !== (exp == 32'h0)) begin
        failed++; $display("FAIL random_result[%0d] op=%0d a=%h b=%h got=%h/%b want=%h/%b",
                           i, op, x, y, r, z, exp, (exp == 32'h0));
      end
      tests++;
      if (lat != ref_lat(op, y)) begin
        failed++; $display("FAIL random_latency[%0d] op=%0d got=%0d want=%0d", i, op, lat, ref_lat(op, y));
      end
    end
  endtask

  task automatic test_backpressure();
    bus.in_valid = 1'b1; bus.ALUControl = 3'd0; bus.a = 32'd100; bus.b = 32'd23;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready  = 1'b0;
    bus.in_valid   = 1'b1;
    bus.ALUControl = 3'd3; bus.a = 32'd2; bus.b = 32'd3;
    tests++;
    if (bus.out_valid !== 1'b1 || bus.result !== 32'd123) begin
      failed++; $display("FAIL bp_first got=%b/%h want=1/0000007b", bus.out_valid, bus.result);
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      tests++;
      if (bus.out_valid !== 1'b1 || bus.result !== 32'd123 || bus.in_ready !== 1'b0) begin
        failed++; $display("FAIL bp_stall[%0d] out_valid=%b result=%h in_ready=%b want 1/0000007b/0",
                           i, bus.out_valid, bus.result, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    #1;
    tests++;
    if (bus.in_ready !== 1'b1) begin
      failed++; $display("FAIL bp_release_in_ready got=%b want=1", bus.in_ready);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    tests++;
    if (bus.out_valid !== 1'b1 || bus.result !== ref_alu(3'd3, 32'd2, 32'd3) || bus.zero !== 1'b0) begin
      failed++; $display("FAIL bp_same_edge got=%b/%h/%b want=1/00000003/0", bus.out_valid, bus.result, bus.zero);
    end
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (bus.out_valid !== 1'b0) begin
      failed++; $display("FAIL bp_drain got=%b want=0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q [$];
    logic [31:0] x, y, e;
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        e = exp_q.pop_front();
        tests++;
        if (bus.out_valid !== 1'b1 || bus.result !== e) begin
          failed++; $display("FAIL b2b_result[%0d] got=%b/%h want=1/%h", i - 1, bus.out_valid, bus.result, e);
        end
      end
      if (i < 4) begin
        x = $urandom; y = $urandom;
        exp_q.push_back(ref_alu(3'd0, x, y));
        bus.in_valid = 1'b1; bus.ALUControl = 3'd0; bus.a = x; bus.b = y;
        tests++;
        if (bus.in_ready !== 1'b1) begin
          failed++; $display("FAIL b2b_in_ready[%0d] got=%b want=1", i, bus.in_ready);
        end
      end else begin
        bus.in_valid = 1'b0;
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midshift();
    logic [31:0] r;
    logic        z;
    int          lat;
    bit          stale;
    run_op(3'd0, 32'd5, 32'd7, r, z, lat);
    bus.in_valid = 1'b1; bus.ALUControl = 3'd6; bus.a = 32'd1; bus.b = 32'd20;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
`ifndef ALU_FAST_SHIFT_EN
    tests++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      failed++; $display("FAIL midshift_busy out_valid=%b in_ready=%b want 0/0", bus.out_valid, bus.in_ready);
    end
`endif
    #1 reset = 1'b1;
    #1;
    tests++;
    if (bus.out_valid !== 1'b0 || bus.result !== 32'h0 || bus.zero !== 1'b1) begin
      failed++; $display("FAIL midshift_reset got=%b/%h/%b want=0/00000000/1", bus.out_valid, bus.result, bus.zero);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.in_ready !== 1'b1) begin
      failed++; $display("FAIL midshift_in_ready got=%b want=1", bus.in_ready);
    end
    stale = 1'b0;
    for (int i = 0; i < 25; i++) begin
      if (bus.out_valid !== 1'b0) stale = 1'b1;
      @(negedge clk);
    end
    tests++;
    if (stale) begin
      failed++; $display("FAIL midshift_stale got=1 want=0");
    end
    run_op(3'd1, 32'd3, 32'd10, r, z, lat);
    tests++;
    if (r !== ref_alu(3'd1, 32'd3, 32'd10) || lat != 1) begin
      failed++; $display("FAIL post_reset_op got=%h lat=%0d want=%h lat=1", r, lat, ref_alu(3'd1, 32'd3, 32'd10));
    end
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.ALUControl = 3'd0;
    bus.a          = '0;
    bus.b          = '0;
    bus.out_ready  = 1'b1;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_midshift();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
